hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter LOAD_USE_STALL, default 1, legal 1..3: bubble cycles inserted per load-use hazard.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 IDrs  input  5  rs field of the instruction in ID.
REQ-005 IDrt  input  5  rt field of the instruction in ID.
REQ-006 IDUsesRt  input  1  1 = ID instruction reads rt as a source.
REQ-007 EXMemRead  input  1  1 = instruction in EX is a load.
REQ-008 EXWriteReg  input  5  destination register of the instruction in EX.
REQ-009 EXBranchTaken  input  1  branch/jump resolved taken in EX this cycle.
REQ-010 CtrlSel  output  2  select for the 9-bit control mux: 0 = controller bits, 1 = all-zero bubble; 2 and 3 are never driven.
REQ-011 PCWrite  output  1  1 = PC may update.
REQ-012 IFIDWrite  output  1  1 = IF/ID register may load.
REQ-013 IFIDFlush  output  1  1 = IF/ID register loads a NOP.
REQ-014 StallCount  output  16  saturating count of stall cycles.
REQ-015 FlushCount  output  16  saturating count of branch-flush cycles.

Function
REQ-016 Load-use hazard (LU) SHALL be EXMemRead & (EXWriteReg != 0) & ((EXWriteReg == IDrs) | (IDUsesRt & EXWriteReg == IDrt)).
REQ-017 The FSM SHALL have exactly two states: RUN and STALL, plus a 2-bit down-counter Cnt.
REQ-018 Outputs SHALL be combinational from state and inputs in the same cycle, with zero latency.
REQ-019 In RUN with EXBranchTaken=1: CtrlSel=1, IFIDFlush=1, PCWrite=1, IFIDWrite=1; this SHALL take priority over LU; the state SHALL remain RUN.
REQ-020 In RUN with LU=1 and no branch: CtrlSel=1, PCWrite=0, IFIDWrite=0, IFIDFlush=0.
REQ-021 On that cycle, if LOAD_USE_STALL>1, the next state SHALL be STALL with Cnt=LOAD_USE_STALL-1; otherwise the next state SHALL be RUN.
REQ-022 In STALL: outputs SHALL be as in REQ-020; Cnt SHALL decrement each cycle; when Cnt==1 the next state SHALL be RUN.
REQ-023 In STALL, EXBranchTaken=1 SHALL force the REQ-019 outputs and a next state of RUN with Cnt=0.
REQ-024 In RUN with no hazard: CtrlSel=0, PCWrite=1, IFIDWrite=1, IFIDFlush=0.
REQ-025 StallCount SHALL increment on every cycle with PCWrite=0.
REQ-026 FlushCount SHALL increment on every cycle with IFIDFlush=1.
REQ-027 Both counters SHALL hold at 16'hFFFF without wrapping.
REQ-028 A write to register $0 SHALL never cause a stall.

Reset
REQ-029 While Rst=1 at a clock edge: state SHALL become RUN, Cnt=0, StallCount=0, FlushCount=0.
REQ-030 During the reset cycle, outputs SHALL be CtrlSel=0, PCWrite=1, IFIDWrite=1, IFIDFlush=0, regardless of inputs.
REQ-031 Rst asserted mid-stall SHALL abort the stall, and no count SHALL be recorded for that cycle.

Structure
REQ-032 CtrlSel encodings (SEL_CTRL=0, SEL_BUBBLE=1) and the state encodings SHALL live in the shared pipeline package used by the datapath muxes.
REQ-033 One sub-module, sat_counter16 (enable, synchronous clear), SHALL be instantiated twice for the counters; there SHALL be no other hierarchy.

Verification
REQ-034 Scenario: LOAD_USE_STALL=1, EXMemRead=1, EXWriteReg=8, IDrs=8 for one cycle -> exactly one cycle with PCWrite=0, IFIDWrite=0, CtrlSel=1; StallCount=1.
REQ-035 Scenario: LOAD_USE_STALL=3, same hazard -> three consecutive stall cycles, then RUN; StallCount=3.
REQ-036 Scenario: EXWriteReg=0, IDrs=0, EXMemRead=1 -> no stall; CtrlSel=0.
REQ-037 Scenario: LU and EXBranchTaken both high -> IFIDFlush=1, PCWrite=1, CtrlSel=1; StallCount unchanged; FlushCount +1.
REQ-038 Scenario: LOAD_USE_STALL=3 with Rst pulsed on the 2nd stall cycle -> next cycle in RUN; both counts=0.
REQ-039 Scenario: 65,540 consecutive flush cycles -> FlushCount=16'hFFFF and held.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions: control-mux select codes, hazard FSM states,
// and the load-use hazard detection function.
package hazard_control_unit_pkg;

    // Select for the 9-bit control mux in front of ID/EX.
    typedef enum logic [1:0] {
        SEL_CTRL   = 2'd0,  // pass the main controller's bits
        SEL_BUBBLE = 2'd1   // all-zero bubble
    } ctrl_sel_t;

    // Hazard unit FSM states.
    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hcu_state_t;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    // A load in EX whose destination is a source of the ID instruction.
    // Register $0 is hard-wired to zero, so it can never create a dependence.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] ex_write_reg,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return mem_read && (ex_write_reg != 5'd0) &&
               ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter16.sv
// 16-bit up-counter with enable and synchronous clear that sticks at all-ones.
module sat_counter16
    import hazard_control_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear wins, otherwise step while enabled and not saturated.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 16'd0;
        end else if (en_i && (count_q != COUNT_MAX)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls (LOAD_USE_STALL bubbles each, 1..3)
// and taken-branch flushes, with saturating event counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  IDrs,
    input  logic [4:0]  IDrt,
    input  logic        IDUsesRt,
    input  logic        EXMemRead,
    input  logic [4:0]  EXWriteReg,
    input  logic        EXBranchTaken,
    output logic [1:0]  CtrlSel,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    // Remaining stall cycles loaded after the first bubble has been issued.
    localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL - 1);

    hcu_state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    ctrl_sel_t  sel_d;
    logic       pc_write_d;
    logic       ifid_write_d;
    logic       ifid_flush_d;
    logic       lu_hazard;

    assign lu_hazard = load_use_hazard(EXMemRead, EXWriteReg, IDrs, IDrt, IDUsesRt);

    // Next-state and zero-latency outputs; reset forces the free-running
    // outputs, and a taken branch overrides any stall (the load gets flushed).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = SEL_CTRL;
        pc_write_d   = 1'b1;
        ifid_write_d = 1'b1;
        ifid_flush_d = 1'b0;
        if (Rst) begin
            state_d = RUN;
            cnt_d   = 2'd0;
        end else if (EXBranchTaken) begin
            sel_d        = SEL_BUBBLE;
            ifid_flush_d = 1'b1;
            state_d      = RUN;
            cnt_d        = 2'd0;
        end else if (state_q == STALL) begin
            sel_d        = SEL_BUBBLE;
            pc_write_d   = 1'b0;
            ifid_write_d = 1'b0;
            if (cnt_q <= 2'd1) begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (lu_hazard) begin
            sel_d        = SEL_BUBBLE;
            pc_write_d   = 1'b0;
            ifid_write_d = 1'b0;
            if (LOAD_USE_STALL > 1) begin
                state_d = STALL;
                cnt_d   = STALL_INIT;
            end
        end
    end

    // FSM state and stall down-counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign CtrlSel   = sel_d;
    assign PCWrite   = pc_write_d;
    assign IFIDWrite = ifid_write_d;
    assign IFIDFlush = ifid_flush_d;

    // Stall cycles are exactly the cycles where the PC is frozen.
    sat_counter16 u_stall_cnt (
        .clk_i   (Clk),
        .clr_i   (Rst),
        .en_i    (~pc_write_d),
        .count_o (StallCount)
    );

    sat_counter16 u_flush_cnt (
        .clk_i   (Clk),
        .clr_i   (Rst),
        .en_i    (ifid_flush_d),
        .count_o (FlushCount)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit with LOAD_USE_STALL = 1 and 3
// instances driven by identical stimulus.
module tb_hazard_control_unit;

    typedef struct {
        logic [1:0]  sel;
        logic        pcw;
        logic        ifw;
        logic        fl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_wr;
    logic        id_uses_rt, ex_mem_read, ex_br;

    logic [1:0]  sel1, sel3;
    logic        pcw1, pcw3, ifw1, ifw3, fl1, fl3;
    logic [15:0] sc1, sc3, fc1, fc3;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q1[$];
    exp_t q3[$];

    // Reference model state per instance (index 0: stall length 1, index 1: length 3).
    int          p_len[2] = '{1, 3};
    int          rem[2];
    logic [15:0] sc_m[2];
    logic [15:0] fc_m[2];

    always #5 clk = ~clk;

    hazard_control_unit #(.LOAD_USE_STALL(1)) u_dut1 (
        .Clk(clk), .Rst(rst), .IDrs(id_rs), .IDrt(id_rt), .IDUsesRt(id_uses_rt),
        .EXMemRead(ex_mem_read), .EXWriteReg(ex_wr), .EXBranchTaken(ex_br),
        .CtrlSel(sel1), .PCWrite(pcw1), .IFIDWrite(ifw1), .IFIDFlush(fl1),
        .StallCount(sc1), .FlushCount(fc1)
    );

    hazard_control_unit #(.LOAD_USE_STALL(3)) u_dut3 (
        .Clk(clk), .Rst(rst), .IDrs(id_rs), .IDrt(id_rt), .IDUsesRt(id_uses_rt),
        .EXMemRead(ex_mem_read), .EXWriteReg(ex_wr), .EXBranchTaken(ex_br),
        .CtrlSel(sel3), .PCWrite(pcw3), .IFIDWrite(ifw3), .IFIDFlush(fl3),
        .StallCount(sc3), .FlushCount(fc3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, expv, $time);
        end
    endtask

    task automatic compare(input string who, input exp_t e, input logic [1:0] sel,
                           input logic pcw, input logic ifw, input logic fl,
                           input logic [15:0] sc, input logic [15:0] fc);
        check_val({who, "_CtrlSel"},    32'(sel), 32'(e.sel));
        check_val({who, "_PCWrite"},    32'(pcw), 32'(e.pcw));
        check_val({who, "_IFIDWrite"},  32'(ifw), 32'(e.ifw));
        check_val({who, "_IFIDFlush"},  32'(fl),  32'(e.fl));
        check_val({who, "_StallCount"}, 32'(sc),  32'(e.sc));
        check_val({who, "_FlushCount"}, 32'(fc),  32'(e.fc));
    endtask

    // One clock of stimulus: predict, push, compare at negedge, advance model.
    task automatic step(input logic r, input logic b, input logic m, input logic [4:0] w,
                        input logic [4:0] s, input logic [4:0] t, input logic u,
                        input bit verbose);
        exp_t        e;
        exp_t        got1;
        exp_t        got3;
        int          nrem[2];
        logic [15:0] nsc[2];
        logic [15:0] nfc[2];
        logic        lu;
        rst = r; ex_br = b; ex_mem_read = m; ex_wr = w; id_rs = s; id_rt = t; id_uses_rt = u;
        lu = m && (w != 5'd0) && ((w == s) || (u && (w == t)));
        for (int d = 0; d < 2; d++) begin
            e.sc = sc_m[d];
            e.fc = fc_m[d];
            nrem[d] = rem[d];
            nsc[d]  = sc_m[d];
            nfc[d]  = fc_m[d];
            if (r) begin
                e.sel = 2'd0; e.pcw = 1'b1; e.ifw = 1'b1; e.fl = 1'b0;
                nrem[d] = 0; nsc[d] = 16'd0; nfc[d] = 16'd0;
            end else if (b) begin
                e.sel = 2'd1; e.pcw = 1'b1; e.ifw = 1'b1; e.fl = 1'b1;
                nrem[d] = 0;
                if (nfc[d] != 16'hFFFF) nfc[d] = nfc[d] + 16'd1;
            end else if ((rem[d] > 0) || lu) begin
                e.sel = 2'd1; e.pcw = 1'b0; e.ifw = 1'b0; e.fl = 1'b0;
                nrem[d] = (rem[d] > 0) ? rem[d] - 1 : p_len[d] - 1;
                if (nsc[d] != 16'hFFFF) nsc[d] = nsc[d] + 16'd1;
            end else begin
                e.sel = 2'd0; e.pcw = 1'b1; e.ifw = 1'b1; e.fl = 1'b0;
            end
            if (d == 0) q1.push_back(e);
            else        q3.push_back(e);
        end
        @(negedge clk);
        got1 = q1.pop_front();
        got3 = q3.pop_front();
        compare("d1", got1, sel1, pcw1, ifw1, fl1, sc1, fc1);
        compare("d3", got3, sel3, pcw3, ifw3, fl3, sc3, fc3);
        if (verbose)
            $display("t=%0t rst=%0d br=%0d mr=%0d wr=%0d rs=%0d rt=%0d urt=%0d | d1 sel=%0d pcw=%0d flush=%0d sc=%0d fc=%0d | d3 sel=%0d pcw=%0d flush=%0d sc=%0d fc=%0d",
                     $time, r, b, m, w, s, t, u, sel1, pcw1, fl1, sc1, fc1, sel3, pcw3, fl3, sc3, fc3);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            rem[d]  = nrem[d];
            sc_m[d] = nsc[d];
            fc_m[d] = nfc[d];
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    endtask

    // Watchdog so a broken clock or hung step still ends the run.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ex_br = 1'b0; ex_mem_read = 1'b0; ex_wr = 5'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rem[d] = 0; sc_m[d] = 16'd0; fc_m[d] = 16'd0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset cycle with hazard and branch both present: outputs stay free-running.
        step(1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1);

        // Single load-use hazard on rs.
        step(1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
        idle(4);
        check_val("lu1_StallCount", 32'(sc1), 32'd1);
        check_val("lu3_StallCount", 32'(sc3), 32'd3);

        // Register $0 never stalls, via rs or rt.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        check_val("r0_StallCount", 32'(sc3), 32'd0);

        // rt hazard only counts when the ID instruction reads rt.
        step(1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1);
        idle(3);
        // Non-load writer never stalls.
        step(1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1);

        // Branch beats load-use.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
        check_val("brlu_StallCount", 32'(sc1), 32'd0);
        check_val("brlu_FlushCount", 32'(fc1), 32'd1);

        // Reset on the second stall cycle aborts the stall and clears counts.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        check_val("rstmid_StallCount", 32'(sc3), 32'd0);
        check_val("rstmid_FlushCount", 32'(fc3), 32'd0);
        idle(2);

        // Branch during a long stall ends it immediately.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle(2);

        // Mixed random traffic over a small register set to hit hazards often.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'b1);
        end

        // Flush counter saturation.
        do_reset();
        for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check_val("sat_FlushCount", 32'(fc1), 32'hFFFF);
        step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        check_val("sat_hold_FlushCount", 32'(fc3), 32'hFFFF);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
